// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus state encoding and default bus sizing
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } bus_state_t;

    localparam int DEF_MASTERS = 2;
    localparam int DEF_SLAVES  = 3;
    localparam int DEF_TIMEOUT = 64;

    // Round-robin successor of a master index, wrapping at the top.
    function automatic int next_master(input int idx, input int masters);
        return (idx == masters - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin search from a start pointer
module rr_picker #(
    parameter  int N = 2,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] index
);

    int           idx;
    logic [W-1:0] idx_w;

    // Walk offsets from farthest to nearest so the nearest eligible master wins.
    always_comb begin
        found = |eligible;
        index = '0;
        idx   = 0;
        idx_w = '0;
        for (int off = N - 1; off >= 0; off--) begin
            idx   = (int'(ptr) + off) % N;
            idx_w = W'(idx);
            if (eligible[idx_w]) begin
                index = idx_w;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin bus arbiter with tenure timeout and release turnaround
module bus_arbiter
    import bus_pkg::*;
#(
    parameter  int MASTERS = DEF_MASTERS,
    parameter  int SLAVES  = DEF_SLAVES,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int MID     = $clog2(MASTERS),
    localparam int SID     = $clog2(SLAVES),
    localparam int CW      = $clog2(TIMEOUT)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [MASTERS-1:0]     req,
    input  logic [MASTERS*SID-1:0] slave_sel,
    input  logic [MASTERS-1:0]     done,
    output logic [MASTERS-1:0]     grant,
    output logic [MID-1:0]         master_sel,
    output logic [SID-1:0]         slave_route,
    output logic                   bus_valid,
    output logic                   timeout_err
);

    bus_state_t         state;
    bus_state_t         state_nxt;
    logic [MASTERS-1:0] eligible;
    logic               found;
    logic [MID-1:0]     pick;
    logic [MID-1:0]     rr_ptr;
    logic [MID-1:0]     win;
    logic [SID-1:0]     route;
    logic [CW-1:0]      tenure;
    logic               win_done;
    logic               term;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < MASTERS; i++) begin
            eligible[i] = req[i] && (int'(slave_sel[i*SID +: SID]) < SLAVES);
        end
    end

    rr_picker #(.N(MASTERS)) u_picker (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .found    (found),
        .index    (pick)
    );

    assign win_done = done[win];
    assign term     = (tenure == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = BUSY;
            BUSY:    if (win_done || term) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant and valid decode straight from state so reset drops them without a clock.
    always_comb begin
        grant     = '0;
        bus_valid = 1'b0;
        if (state == BUSY) begin
            grant[win] = 1'b1;
            bus_valid  = 1'b1;
        end
    end

    // timeout_err is registered: it is high during the RELEASE cycle that a forced end produces.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            win         <= '0;
            route       <= '0;
            tenure      <= '0;
            rr_ptr      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= (state == BUSY) && term && !win_done;
            if (state == IDLE && found) begin
                win    <= pick;
                route  <= slave_sel[int'(pick)*SID +: SID];
                tenure <= '0;
            end else if (state == BUSY && !term) begin
                tenure <= tenure + 1'b1;
            end
            if (state == RELEASE) begin
                rr_ptr <= MID'(next_master(int'(win), MASTERS));
            end
        end
    end

    assign master_sel  = win;
    assign slave_route = route;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter against a transaction-level model
module tb_bus_arbiter;

    localparam int M = 2;
    localparam int S = 3;
    localparam int T = 64;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [1:0] req = '0;
    logic [3:0] slave_sel = '0;
    logic [1:0] done = '0;
    logic [1:0] grant;
    logic [0:0] master_sel;
    logic [1:0] slave_route;
    logic       bus_valid;
    logic       timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: who owns the bus, how long, cooldown cycles before arbitration, fairness pointer.
    int m_owner, m_age, m_cool, m_ptr, m_route, m_msel;
    bit m_terr;

    bus_arbiter #(.MASTERS(M), .SLAVES(S), .TIMEOUT(T)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req         (req),
        .slave_sel   (slave_sel),
        .done        (done),
        .grant       (grant),
        .master_sel  (master_sel),
        .slave_route (slave_route),
        .bus_valid   (bus_valid),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int sel_of(input int i);
        logic [3:0] v;
        v = slave_sel;
        return int'(v[i*2 +: 2]);
    endfunction

    task automatic model_reset();
        m_owner = -1; m_age = 0; m_cool = 0; m_ptr = 0;
        m_route = 0; m_msel = 0; m_terr = 0;
    endtask

    task automatic model_end(input bit forced);
        m_ptr   = (m_owner + 1) % M;
        m_owner = -1;
        m_cool  = 1;
        m_terr  = forced;
    endtask

    task automatic model_step();
        bit got;
        int i;
        m_terr = 0;
        if (m_owner >= 0) begin
            if (done[m_owner]) model_end(0);
            else if (m_age == T - 1) model_end(1);
            else m_age++;
        end else if (m_cool > 0) begin
            m_cool--;
        end else begin
            got = 0;
            for (int k = 0; k < M; k++) begin
                i = (m_ptr + k) % M;
                if (!got && req[i] && sel_of(i) < S) begin
                    got = 1; m_owner = i; m_age = 0; m_route = sel_of(i); m_msel = i;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0; done = '0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(posedge clk);
        @(negedge clk);
        n_cmp += 5;
        if (grant !== 2'b00) begin n_bad++; $display("FAIL reset_grant got=%b exp=00", grant); end
        if (bus_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", bus_valid); end
        if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_terr got=%b exp=0", timeout_err); end
        if (master_sel !== 1'b0) begin n_bad++; $display("FAIL reset_msel got=%0d exp=0", master_sel); end
        if (slave_route !== 2'd0) begin n_bad++; $display("FAIL reset_route got=%0d exp=0", slave_route); end
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        req = 2'b01; slave_sel = 4'b00_10;
        tick();
        n_cmp += 4;
        if (grant !== 2'b01) begin n_bad++; $display("FAIL single_grant got=%b exp=01", grant); end
        if (slave_route !== 2'd2) begin n_bad++; $display("FAIL single_route got=%0d exp=2", slave_route); end
        if (bus_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b exp=1", bus_valid); end
        if (master_sel !== 1'b0) begin n_bad++; $display("FAIL single_msel got=%0d exp=0", master_sel); end
        tick(); tick();
        done = 2'b01; tick(); done = '0;
        n_cmp += 3;
        if (grant !== 2'b00) begin n_bad++; $display("FAIL single_rel_grant got=%b exp=00", grant); end
        if (bus_valid !== 1'b0) begin n_bad++; $display("FAIL single_rel_valid got=%b exp=0", bus_valid); end
        if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL single_rel_terr got=%b exp=0", timeout_err); end
        req = '0; tick();
        n_cmp++;
        if (grant !== 2'b00) begin n_bad++; $display("FAIL single_idle_grant got=%b exp=00", grant); end
    endtask

    task automatic test_fairness();
        logic [1:0] exp;
        int w;
        do_reset();
        req = 2'b11; slave_sel = 4'b10_01;
        for (int t = 0; t < 4; t++) begin
            exp = (t % 2 == 0) ? 2'b01 : 2'b10;
            w = 0;
            while (!bus_valid && w < 10) begin tick(); w++; end
            if (t > 0) begin
                n_cmp++;
                if (w !== 2) begin n_bad++; $display("FAIL fair_gap t=%0d got=%0d exp=2", t, w); end
            end
            n_cmp += 2;
            if (grant !== exp) begin n_bad++; $display("FAIL fair_grant t=%0d got=%b exp=%b", t, grant, exp); end
            if (slave_route !== ((t % 2 == 0) ? 2'd1 : 2'd2)) begin
                n_bad++; $display("FAIL fair_route t=%0d got=%0d", t, slave_route);
            end
            for (int c = 0; c < 4; c++) tick();
            n_cmp++;
            if (grant !== exp) begin n_bad++; $display("FAIL fair_hold t=%0d got=%b exp=%b", t, grant, exp); end
            done = exp; tick(); done = '0;
        end
    endtask

    task automatic test_timeout();
        int w, busy;
        do_reset();
        req = 2'b10; slave_sel = 4'b01_00;
        w = 0;
        while (!bus_valid && w < 10) begin tick(); w++; end
        n_cmp++;
        if (grant !== 2'b10) begin n_bad++; $display("FAIL tmo_grant got=%b exp=10", grant); end
        req = 2'b01;
        busy = 1;
        while (bus_valid && busy < 200) begin
            tick();
            if (bus_valid) begin
                busy++;
                n_cmp++;
                if (grant !== 2'b10) begin n_bad++; $display("FAIL tmo_hold cyc=%0d got=%b exp=10", busy, grant); end
            end
        end
        n_cmp += 3;
        if (busy !== T) begin n_bad++; $display("FAIL tmo_len got=%0d exp=%0d", busy, T); end
        if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL tmo_err got=%b exp=1", timeout_err); end
        if (grant !== 2'b00) begin n_bad++; $display("FAIL tmo_drop got=%b exp=00", grant); end
        tick();
        n_cmp++;
        if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL tmo_pulse got=%b exp=0", timeout_err); end
        tick();
        n_cmp++;
        if (grant !== 2'b01) begin n_bad++; $display("FAIL tmo_next got=%b exp=01", grant); end
    endtask

    task automatic test_collision();
        int busy;
        busy = 1;
        while (busy < T) begin tick(); busy++; end
        n_cmp++;
        if (bus_valid !== 1'b1) begin n_bad++; $display("FAIL coll_valid got=%b exp=1", bus_valid); end
        done = 2'b01; tick(); done = '0;
        n_cmp += 2;
        if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL coll_terr got=%b exp=0", timeout_err); end
        if (grant !== 2'b00) begin n_bad++; $display("FAIL coll_grant got=%b exp=00", grant); end
    endtask

    task automatic test_invalid_target();
        int g1;
        do_reset();
        req = 2'b11; slave_sel = 4'b01_11;
        g1 = 0;
        for (int c = 0; c < 40; c++) begin
            done = bus_valid ? 2'b10 : 2'b00;
            tick();
            done = '0;
            n_cmp++;
            if (grant[0] !== 1'b0) begin n_bad++; $display("FAIL inval_grant0 c=%0d got=%b exp=0", c, grant[0]); end
            if (grant == 2'b10 && done == 2'b00) g1++;
        end
        n_cmp++;
        if (g1 < 10) begin n_bad++; $display("FAIL inval_m1_grants got=%0d exp>=10", g1); end
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        req = 2'b11; slave_sel = 4'b00_01;
        tick();
        n_cmp++;
        if (grant !== 2'b01) begin n_bad++; $display("FAIL rst_pre_grant got=%b exp=01", grant); end
        tick();
        done = 2'b10; tick(); done = '0;
        n_cmp++;
        if (grant !== 2'b01) begin n_bad++; $display("FAIL rst_other_done got=%b exp=01", grant); end
        #2 resetn = 1'b0;
        #1;
        n_cmp += 3;
        if (grant !== 2'b00) begin n_bad++; $display("FAIL rst_async_grant got=%b exp=00", grant); end
        if (bus_valid !== 1'b0) begin n_bad++; $display("FAIL rst_async_valid got=%b exp=0", bus_valid); end
        if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL rst_async_terr got=%b exp=0", timeout_err); end
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        tick();
        n_cmp += 2;
        if (grant !== 2'b01) begin n_bad++; $display("FAIL rst_first got=%b exp=01", grant); end
        if (master_sel !== 1'b0) begin n_bad++; $display("FAIL rst_first_msel got=%0d exp=0", master_sel); end
    endtask

    task automatic test_random();
        logic [1:0] eg;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            req       = 2'($urandom);
            slave_sel = 4'($urandom);
            done      = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            tick();
            eg = (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
            n_cmp += 5;
            if (grant !== eg) begin n_bad++; $display("FAIL rand_grant c=%0d got=%b exp=%b", c, grant, eg); end
            if (bus_valid !== (m_owner >= 0)) begin n_bad++; $display("FAIL rand_valid c=%0d got=%b", c, bus_valid); end
            if (timeout_err !== m_terr) begin n_bad++; $display("FAIL rand_terr c=%0d got=%b exp=%b", c, timeout_err, m_terr); end
            if (master_sel !== 1'(m_msel)) begin n_bad++; $display("FAIL rand_msel c=%0d got=%0d exp=%0d", c, master_sel, m_msel); end
            if (slave_route !== 2'(m_route)) begin n_bad++; $display("FAIL rand_route c=%0d got=%0d exp=%0d", c, slave_route, m_route); end
        end
        done = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_collision();
        test_invalid_target();
        test_reset_mid_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
